// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller slice.
//   seg7_ctrl_state_t : controller FSM states (IDLE, SCAN, COMMIT)
//   SEG7_W            : segment pattern width (g..a)
//   SEG7_BLANK        : active-low all-segments-off pattern
package seg7_pkg;

  localparam int unsigned SEG7_W = 7;
  localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } seg7_ctrl_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to seven-segment pattern decoder (combinational).
//   n_rst : active-low reset; pattern is blank while asserted
//   i_hex : 4-bit value to display
//   o_hex : active-low segments, bit order g..a
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic              n_rst,
  input  logic [3:0]        i_hex,
  output logic [SEG7_W-1:0] o_hex
);

  logic [SEG7_W-1:0] pat;

  always_comb begin
    pat = SEG7_BLANK;
    case (i_hex)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = SEG7_BLANK;
    endcase
  end

  assign o_hex = n_rst ? pat : SEG7_BLANK;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller. Accepts a packed hex value via
// valid/ready, decodes one digit per cycle (MSD first) into a shadow
// register through a single shared decoder, then commits all digits at once.
//   clk, n_rst : clock, asynchronous active-low reset
//   i_valid    : i_value valid for transfer
//   o_ready    : high only in IDLE
//   i_value    : packed nibbles, digit 0 rightmost
//   o_hex      : active-low segment patterns, 7 bits per digit (g..a)
//   o_done     : one-cycle pulse after a commit
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 is always shown).
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [4*NUM_DIGITS-1:0]      i_value,
  output logic [SEG7_W*NUM_DIGITS-1:0] o_hex,
  output logic                         o_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  seg7_ctrl_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [SEG7_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [SEG7_W*NUM_DIGITS-1:0] hex_q, hex_d;
  logic done_q, done_d;

  logic [3:0]        nibble;
  logic [SEG7_W-1:0] dec_hex;
  logic [SEG7_W-1:0] wr_pat;

  always_comb begin
    nibble = 4'h0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nibble = val_q[4*i +: 4];
    end
  end

  seg7_decoder u_dec (
    .n_rst (n_rst),
    .i_hex (nibble),
    .o_hex (dec_hex)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic seen_nz_q, seen_nz_d;

  // Blank only zeros that precede the first nonzero digit; digit 0 always shows.
  always_comb begin
    seen_nz_d = seen_nz_q;
    if (state_q == IDLE && i_valid) seen_nz_d = 1'b0;
    else if (state_q == SCAN && nibble != 4'h0) seen_nz_d = 1'b1;
    wr_pat = (!seen_nz_q && nibble == 4'h0 && idx_q != '0) ? SEG7_BLANK : dec_hex;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) seen_nz_q <= 1'b0;
    else        seen_nz_q <= seen_nz_d;
  end
`else
  assign wr_pat = dec_hex;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    val_d    = val_q;
    shadow_d = shadow_q;
    hex_d    = hex_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          val_d   = i_value;
          idx_d   = IDX_LAST;
          state_d = SCAN;
        end
      end
      SCAN: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) shadow_d[SEG7_W*i +: SEG7_W] = wr_pat;
        end
        if (idx_q == '0) state_d = COMMIT;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      COMMIT: begin
        hex_d   = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      val_q    <= '0;
      shadow_q <= '1;
      hex_q    <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
      done_q   <= done_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_hex   = hex_q;
  assign o_done  = done_q;

endmodule
